mpll_lock_ctrl: RTL and testbench

//  Supervises the main VCXO PLL loop. Measures the PFD error pulse width in every reference period and gates the
//  PFD drive to the charge pump. Declares lock, and freezes VCXO tuning (holdover) when the 80 kHz reference strobe

---
 rtl/mpll_lock_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mpll_lock_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpll_lock_ctrl.sv
// rtl/mpll_lock_ctrl.sv - VCXO PLL lock supervisor: error-pulse measurement, lock FSM, holdover gating
module mpll_lock_ctrl #(
    parameter int CNT_WIDTH    = 11,
    parameter int LOCK_THRESH  = 8,
    parameter int LOCK_COUNT   = 256,
    parameter int UNLOCK_COUNT = 4,
    parameter int REF_TIMEOUT  = 4096
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ref_strobe,
    input  logic                 pfd_pol,
    input  logic                 pfd_enable,
    output logic                 cp_pol,
    output logic                 cp_enable,
    output logic                 locked,
    output logic                 ref_present,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] err_width
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;
    localparam logic [1:0] ST_HOLDOVER = 2'd3;

    localparam int WD_W = $clog2(REF_TIMEOUT + 1);
    localparam int GC_W = $clog2(LOCK_COUNT + 1);
    localparam int BC_W = $clog2(UNLOCK_COUNT + 1);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [WD_W-1:0]      WD_MAX  = WD_W'(REF_TIMEOUT);
    localparam logic [WD_W-1:0]      WD_LAST = WD_W'(REF_TIMEOUT - 1);
    localparam logic [GC_W-1:0]      GC_MAX  = GC_W'(LOCK_COUNT);
    localparam logic [BC_W-1:0]      BC_MAX  = BC_W'(UNLOCK_COUNT);

    logic [1:0]           state_q, state_d;
    logic                 skip_q, skip_d;
    logic [CNT_WIDTH-1:0] ecnt_q, ecnt_d;
    logic [CNT_WIDTH-1:0] err_width_q, err_width_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [GC_W-1:0]      gcnt_q, gcnt_d;
    logic [BC_W-1:0]      bcnt_q, bcnt_d;
    logic                 cp_pol_q, cp_pol_d;
    logic                 cp_enable_q, cp_enable_d;
    logic                 locked_q, locked_d;
    logic                 ref_present_q, ref_present_d;

    logic [CNT_WIDTH:0]   ecnt_sum;
    logic [CNT_WIDTH-1:0] meas;
    logic                 good;
    logic                 timeout;
    logic [GC_W-1:0]      gcnt_inc;
    logic [BC_W-1:0]      bcnt_inc;
    logic                 drive_ok;

    // Error-pulse counter; the strobe cycle's own enable is folded into the measurement.
    always_comb begin
        ecnt_sum    = {1'b0, ecnt_q} + {{CNT_WIDTH{1'b0}}, pfd_enable};
        meas        = ecnt_sum[CNT_WIDTH] ? CNT_MAX : ecnt_sum[CNT_WIDTH-1:0];
        good        = (int'(meas) <= LOCK_THRESH);
        err_width_d = err_width_q;
        ecnt_d      = meas;
        if (ref_strobe) begin
            err_width_d = meas;
            ecnt_d      = '0;
        end
    end

    // Reference watchdog; a strobe on the expiring cycle cancels the timeout.
    always_comb begin
        if (ref_strobe) begin
            wd_d = '0;
        end else if (wd_q == WD_MAX) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
        timeout       = !ref_strobe && (wd_q == WD_LAST);
        ref_present_d = (wd_d < WD_MAX);
    end

    // Lock FSM, advanced only on period boundaries (strobe) or reference loss.
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        gcnt_d   = gcnt_q;
        bcnt_d   = bcnt_q;
        gcnt_inc = (gcnt_q == GC_MAX) ? gcnt_q : gcnt_q + GC_W'(1);
        bcnt_inc = (bcnt_q == BC_MAX) ? bcnt_q : bcnt_q + BC_W'(1);
        if (ref_strobe) begin
            case (state_q)
                ST_ACQUIRE: begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else if (good) begin
                        gcnt_d = gcnt_inc;
                        if (gcnt_inc == GC_MAX) begin
                            state_d = ST_LOCKED;
                            bcnt_d  = '0;
                        end
                    end else begin
                        gcnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!good) begin
                        bcnt_d = bcnt_inc;
                        if (bcnt_inc == BC_MAX) begin
                            state_d = ST_ACQUIRE;
                            gcnt_d  = '0;
                        end
                    end else begin
                        bcnt_d = '0;
                    end
                end
                default: begin
                    // IDLE or HOLDOVER: the period in progress is partial, so skip it.
                    state_d = ST_ACQUIRE;
                    skip_d  = 1'b1;
                    gcnt_d  = '0;
                    bcnt_d  = '0;
                end
            endcase
        end else if (timeout && (state_q == ST_ACQUIRE || state_q == ST_LOCKED)) begin
            state_d = ST_HOLDOVER;
        end
    end

    // Charge-pump gating follows the next state so the pump tri-states together with HOLDOVER/IDLE.
    always_comb begin
        drive_ok    = (state_d == ST_ACQUIRE) || (state_d == ST_LOCKED);
        cp_enable_d = drive_ok ? pfd_enable : 1'b0;
        cp_pol_d    = drive_ok ? pfd_pol : cp_pol_q;
        locked_d    = (state_q == ST_LOCKED);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            skip_q        <= 1'b0;
            ecnt_q        <= '0;
            err_width_q   <= '0;
            wd_q          <= '0;
            gcnt_q        <= '0;
            bcnt_q        <= '0;
            cp_pol_q      <= 1'b0;
            cp_enable_q   <= 1'b0;
            locked_q      <= 1'b0;
            ref_present_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_q        <= skip_d;
            ecnt_q        <= ecnt_d;
            err_width_q   <= err_width_d;
            wd_q          <= wd_d;
            gcnt_q        <= gcnt_d;
            bcnt_q        <= bcnt_d;
            cp_pol_q      <= cp_pol_d;
            cp_enable_q   <= cp_enable_d;
            locked_q      <= locked_d;
            ref_present_q <= ref_present_d;
        end
    end

    assign cp_pol      = cp_pol_q;
    assign cp_enable   = cp_enable_q;
    assign locked      = locked_q;
    assign ref_present = ref_present_q;
    assign state       = state_q;
    assign err_width   = err_width_q;

endmodule

// File: tb/tb_mpll_lock_ctrl.sv
// tb/tb_mpll_lock_ctrl.sv - randomized self-checking bench for mpll_lock_ctrl
module tb_mpll_lock_ctrl;

    localparam int CW   = 11;
    localparam int LT   = 8;
    localparam int LC   = 4;
    localparam int UC   = 2;
    localparam int TO   = 64;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          ref_strobe;
    logic          pfd_pol;
    logic          pfd_enable;
    logic          cp_pol;
    logic          cp_enable;
    logic          locked;
    logic          ref_present;
    logic [1:0]    state;
    logic [CW-1:0] err_width;

    int pass_cnt = 0;
    int total    = 0;

    // reference model state (plain integers, period-level rules)
    int m_state, m_skip, m_ecnt, m_wd, m_gcnt, m_bcnt, m_err;
    int m_cp_pol, m_cp_en, m_locked, m_refp;

    mpll_lock_ctrl #(
        .CNT_WIDTH(CW), .LOCK_THRESH(LT), .LOCK_COUNT(LC),
        .UNLOCK_COUNT(UC), .REF_TIMEOUT(TO)
    ) dut (
        .clock(clk), .reset(reset), .ref_strobe(ref_strobe),
        .pfd_pol(pfd_pol), .pfd_enable(pfd_enable),
        .cp_pol(cp_pol), .cp_enable(cp_enable), .locked(locked),
        .ref_present(ref_present), .state(state), .err_width(err_width)
    );

    always #5 clk = ~clk;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_clock(input bit s, input bit p, input bit e, input bit r);
        int prev, nxt, m, nwd;
        bit to, good;
        if (r) begin
            m_state = 0; m_skip = 0; m_ecnt = 0; m_wd = 0; m_gcnt = 0; m_bcnt = 0;
            m_err = 0; m_cp_pol = 0; m_cp_en = 0; m_locked = 0; m_refp = 0;
            return;
        end
        prev = m_state;
        nxt  = prev;
        nwd  = s ? 0 : imin(m_wd + 1, TO);
        to   = !s && (m_wd < TO) && (nwd == TO);
        good = 1'b1;
        if (s) begin
            m      = imin(m_ecnt + int'(e), MAXC);
            m_err  = m;
            m_ecnt = 0;
            good   = (m <= LT);
        end else begin
            m_ecnt = imin(m_ecnt + int'(e), MAXC);
        end
        m_wd = nwd;
        if (s) begin
            if (prev == 0 || prev == 3) begin
                nxt = 1; m_skip = 1; m_gcnt = 0; m_bcnt = 0;
            end else if (prev == 1) begin
                if (m_skip != 0) m_skip = 0;
                else if (good) begin
                    m_gcnt = imin(m_gcnt + 1, LC);
                    if (m_gcnt == LC) begin nxt = 2; m_bcnt = 0; end
                end else m_gcnt = 0;
            end else begin
                if (!good) begin
                    m_bcnt = imin(m_bcnt + 1, UC);
                    if (m_bcnt == UC) begin nxt = 1; m_gcnt = 0; end
                end else m_bcnt = 0;
            end
        end else if (to && (prev == 1 || prev == 2)) begin
            nxt = 3;
        end
        m_locked = (prev == 2) ? 1 : 0;
        m_refp   = (nwd < TO) ? 1 : 0;
        if (nxt == 1 || nxt == 2) begin
            m_cp_en = int'(e); m_cp_pol = int'(p);
        end else begin
            m_cp_en = 0;
        end
        m_state = nxt;
    endtask

    task automatic step(input bit s, input bit p, input bit e, input bit r);
        ref_strobe = s; pfd_pol = p; pfd_enable = e; reset = r;
        @(posedge clk);
        model_clock(s, p, e, r);
        #1;
    endtask

    task automatic run_period(input int len, input int errs);
        int off;
        off = $urandom_range(len - errs, 0);
        for (int i = 0; i < len; i++)
            step(i == len - 1, 1'($urandom % 2), (i >= off) && (i < off + errs), 1'b0);
    endtask

    task automatic test_reset();
        step(0, 0, 0, 1);
        step(0, 1, 1, 1);
        total++; if (state !== 2'd0) $display("FAIL reset_state got %0d want 0", state); else pass_cnt++;
        total++; if (cp_enable !== 1'b0 || cp_pol !== 1'b0) $display("FAIL reset_cp got %b%b want 00", cp_pol, cp_enable); else pass_cnt++;
        total++; if (locked !== 1'b0 || ref_present !== 1'b0) $display("FAIL reset_flags got %b%b want 00", locked, ref_present); else pass_cnt++;
        total++; if (err_width !== '0) $display("FAIL reset_err got %0d want 0", err_width); else pass_cnt++;
    endtask

    task automatic test_acquire_lock();
        for (int k = 1; k <= 7; k++) begin
            run_period(40, 3);
            total++;
            if (state !== 2'(m_state) || err_width !== CW'(m_err))
                $display("FAIL acq_period%0d got st=%0d err=%0d want st=%0d err=%0d", k, state, err_width, m_state, m_err);
            else pass_cnt++;
        end
        total++; if (err_width !== CW'(3)) $display("FAIL acq_err got %0d want 3", err_width); else pass_cnt++;
        total++; if (state !== 2'd2 || locked !== 1'b1) $display("FAIL acq_locked got st=%0d lk=%b want st=2 lk=1", state, locked); else pass_cnt++;
    endtask

    task automatic test_unlock();
        run_period(40, 20);
        run_period(40, 2);
        step(0, 0, 0, 0);
        total++; if (state !== 2'd2 || locked !== 1'b1) $display("FAIL unlock_one_bad got st=%0d lk=%b want st=2 lk=1", state, locked); else pass_cnt++;
        run_period(39, 20);
        run_period(40, 20);
        total++; if (state !== 2'd1) $display("FAIL unlock_state got %0d want 1", state); else pass_cnt++;
        step(0, 0, 0, 0);
        total++; if (locked !== 1'b0 || locked !== 1'(m_locked)) $display("FAIL unlock_locked got %b want 0", locked); else pass_cnt++;
    endtask

    task automatic test_holdover();
        for (int k = 0; k < 6; k++) run_period(40, 2);
        total++; if (state !== 2'd2) $display("FAIL hold_prelock got %0d want 2", state); else pass_cnt++;
        for (int k = 1; k <= 70; k++) begin
            step(0, 0, 0, 0);
            if (k == 63) begin
                total++; if (state !== 2'd2 || ref_present !== 1'b1) $display("FAIL hold_k63 got st=%0d rp=%b want st=2 rp=1", state, ref_present); else pass_cnt++;
            end
            if (k == 64) begin
                total++;
                if (state !== 2'd3 || cp_enable !== 1'b0 || ref_present !== 1'b0)
                    $display("FAIL hold_k64 got st=%0d cpe=%b rp=%b want st=3 cpe=0 rp=0", state, cp_enable, ref_present);
                else pass_cnt++;
            end
        end
        step(1, 0, 0, 0);
        total++; if (state !== 2'd1 || ref_present !== 1'b1) $display("FAIL hold_restart got st=%0d rp=%b want st=1 rp=1", state, ref_present); else pass_cnt++;
    endtask

    task automatic test_saturate();
        run_period(3001, 3000);
        total++; if (err_width !== CW'(MAXC)) $display("FAIL sat_err got %0d want %0d", err_width, MAXC); else pass_cnt++;
        total++; if (state !== 2'(m_state)) $display("FAIL sat_state got %0d want %0d", state, m_state); else pass_cnt++;
    endtask

    task automatic test_passthrough();
        bit p, e;
        int bad;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            p = 1'($urandom % 2); e = 1'($urandom % 2);
            step(0, p, e, 0);
            if (cp_pol !== p || cp_enable !== e || state !== 2'd1) bad++;
        end
        total++; if (bad != 0) $display("FAIL pass_acq got %0d bad cycles want 0", bad); else pass_cnt++;
        step(0, 0, 0, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1'($urandom % 2), 1'b1, 0);
            if (cp_enable !== 1'b0) bad++;
        end
        total++; if (bad != 0) $display("FAIL pass_idle got %0d enabled cycles want 0", bad); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 7; k++) run_period(40, 1);
        total++; if (state !== 2'd2 || locked !== 1'b1) $display("FAIL rmid_pre got st=%0d lk=%b want st=2 lk=1", state, locked); else pass_cnt++;
        step(1, 1, 1, 1);
        total++;
        if (state !== 2'd0 || locked !== 1'b0 || cp_enable !== 1'b0 || err_width !== '0)
            $display("FAIL rmid got st=%0d lk=%b cpe=%b err=%0d want 0 0 0 0", state, locked, cp_enable, err_width);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int len, errs, off, bad;
        bit s, e;
        bad = 0;
        for (int k = 0; k < 45; k++) begin
            len  = (k % 9 == 8) ? 80 : int'($urandom_range(50, 30));
            errs = int'($urandom_range(14, 0));
            off  = int'($urandom_range(len - errs, 0));
            for (int i = 0; i < len; i++) begin
                s = (i == len - 1);
                e = (i >= off) && (i < off + errs);
                step(s, 1'($urandom % 2), e, 0);
                if (state !== 2'(m_state) || locked !== 1'(m_locked) || cp_enable !== 1'(m_cp_en) ||
                    cp_pol !== 1'(m_cp_pol) || ref_present !== 1'(m_refp) || err_width !== CW'(m_err)) begin
                    if (bad < 5)
                        $display("FAIL random k=%0d i=%0d got st=%0d lk=%b cpe=%b cpp=%b rp=%b err=%0d want %0d %0d %0d %0d %0d %0d",
                                 k, i, state, locked, cp_enable, cp_pol, ref_present, err_width,
                                 m_state, m_locked, m_cp_en, m_cp_pol, m_refp, m_err);
                    bad++;
                end
            end
        end
        total++; if (bad != 0) $display("FAIL random_total got %0d bad cycles want 0", bad); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; ref_strobe = 1'b0; pfd_pol = 1'b0; pfd_enable = 1'b0;
        test_reset();
        test_acquire_lock();
        test_unlock();
        test_holdover();
        test_saturate();
        test_passthrough();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
